cr_req_arb: RTL

Round-robin arbiter granting a single shared local resource to up to `pReqs` requesters that live in foreign or asynchronous clock domains. Each requester runs a four-phase Req/Ack handshake. The block synchronizes each incoming Req through a `cr_sync` instance, arbitrates in the local clock domain, and presents a one-hot grant to the local resource owner. Ack returns to the requester only after the owner signals Done.

---
 rtl/cr_pkg.sv | 21 ++
 rtl/cr_sync.sv | 45 ++++
 rtl/cr_req_arb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cr_pkg.sv
// cr_pkg: shared types and helpers for the cr_* request/grant blocks.
//   cr_state_e : arbiter FSM state encoding
//   clog2()    : ceil(log2(n)), minimum 1, usable in constant expressions
package cr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } cr_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cr_sync.sv
// cr_sync: 2-flop synchronizer for a vector of independent async bits.
//   i_clk    : destination clock
//   i_rst_n  : active-low reset (async when pRstMode=0, sync otherwise)
//   i_d      : asynchronous input bits
//   o_q      : synchronized bits, two destination-clock edges of latency
module cr_sync #(
    parameter int pWidth   = 1,
    parameter int pRstMode = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [pWidth-1:0] i_d,
    output logic [pWidth-1:0] o_q
);

    logic [pWidth-1:0] r_meta;
    logic [pWidth-1:0] r_sync;

    generate
        if (pRstMode == 0) begin : g_async
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_meta <= '0;
                    r_sync <= '0;
                end else begin
                    r_meta <= i_d;
                    r_sync <= r_meta;
                end
            end
        end else begin : g_sync
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_meta <= '0;
                    r_sync <= '0;
                end else begin
                    r_meta <= i_d;
                    r_sync <= r_meta;
                end
            end
        end
    endgenerate

    assign o_q = r_sync;

endmodule

// File: rtl/cr_req_arb.sv
// cr_req_arb: round-robin arbiter for requesters in foreign clock domains,
// each running a four-phase Req/Ack handshake. Req is synchronized, one
// requester at a time is granted to the local owner, and Ack is returned
// only after the owner pulses Done.
//   Clk, Rst_n : local clock, async active-low reset
//   Req        : per-requester request (async to Clk)
//   Ack        : per-requester acknowledge (registered)
//   Gnt/GntVld/GntIdx : one-hot grant, valid, index (0 when not valid)
//   Done       : owner pulse ending the grant
//   Abort      : pulse, granted requester withdrew before Done
//   Err        : pulse, release timeout
// Optional feature macro: CR_REQ_ARB_TIMEOUT_EN enables the release timeout
// and per-requester masking; otherwise RELEASE waits forever and Err is 0.
module cr_req_arb
    import cr_pkg::*;
#(
    parameter int pReqs     = 4,
    parameter int pTimeoutW = 8
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [pReqs-1:0]          Req,
    output logic [pReqs-1:0]          Ack,
    output logic [pReqs-1:0]          Gnt,
    output logic                      GntVld,
    output logic [clog2(pReqs)-1:0]   GntIdx,
    input  logic                      Done,
    output logic                      Abort,
    output logic                      Err
);

    localparam int IW = clog2(pReqs);

    // First set bit strictly after 'last', cyclically. Scanning from the
    // farthest candidate to the nearest lets the nearest one win.
    function automatic logic [IW-1:0] rr_pick(input logic [pReqs-1:0] req,
                                              input logic [IW-1:0]    last);
        logic [IW-1:0] sel;
        int            idx;
        sel = last;
        for (int k = pReqs; k >= 1; k--) begin
            idx = (int'(last) + k) % pReqs;
            if (req[idx]) sel = IW'(idx);
        end
        return sel;
    endfunction

    cr_state_e          r_state, w_nxt_state;
    logic [IW-1:0]      r_last,  w_nxt_last;   // also the granted index g
    logic [pReqs-1:0]   r_ack,   w_nxt_ack;
    logic [pReqs-1:0]   r_gnt,   w_nxt_gnt;
    logic               r_gvld,  w_nxt_gvld;
    logic [IW-1:0]      r_gidx,  w_nxt_gidx;
    logic               r_abort, w_nxt_abort;

    logic [pReqs-1:0]   w_reqs;
    logic [pReqs-1:0]   w_elig;
    logic [IW-1:0]      w_pick;
    logic [pReqs-1:0]   w_pick_oh;
    logic               w_g_req;

    cr_sync #(
        .pWidth   (pReqs),
        .pRstMode (0)
    ) u_sync (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_d     (Req),
        .o_q     (w_reqs)
    );

`ifdef CR_REQ_ARB_TIMEOUT_EN
    logic [pTimeoutW-1:0] r_cnt,  w_nxt_cnt;
    logic [pTimeoutW-1:0] w_cnt_inc;
    logic [pReqs-1:0]     r_mask, w_nxt_mask;
    logic                 r_err,  w_nxt_err;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_elig    = w_reqs & ~r_mask;
    assign Err       = r_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (pTimeoutW > 0);
    assign w_elig       = w_reqs;
    assign Err          = 1'b0;
`endif

    assign w_pick    = rr_pick(w_elig, r_last);
    assign w_pick_oh = {{(pReqs-1){1'b0}}, 1'b1} << w_pick;
    assign w_g_req   = w_reqs[r_last];

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_last  = r_last;
        w_nxt_ack   = r_ack;
        w_nxt_gnt   = r_gnt;
        w_nxt_gvld  = r_gvld;
        w_nxt_gidx  = r_gidx;
        w_nxt_abort = 1'b0;
`ifdef CR_REQ_ARB_TIMEOUT_EN
        w_nxt_cnt   = r_cnt;
        w_nxt_err   = 1'b0;
        // A masked requester becomes eligible again once its Req is seen low.
        w_nxt_mask  = r_mask & w_reqs;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_nxt_gnt   = w_pick_oh;
                    w_nxt_gvld  = 1'b1;
                    w_nxt_gidx  = w_pick;
                    w_nxt_last  = w_pick;
                    w_nxt_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Withdrawal wins over a simultaneous Done.
                if (!w_g_req) begin
                    w_nxt_gnt   = '0;
                    w_nxt_gvld  = 1'b0;
                    w_nxt_gidx  = '0;
                    w_nxt_abort = 1'b1;
                    w_nxt_state = ST_IDLE;
                end else if (Done) begin
                    w_nxt_gnt   = '0;
                    w_nxt_gvld  = 1'b0;
                    w_nxt_gidx  = '0;
                    w_nxt_ack   = r_gnt;
                    w_nxt_state = ST_RELEASE;
`ifdef CR_REQ_ARB_TIMEOUT_EN
                    w_nxt_cnt   = '0;
`endif
                end
            end
            ST_RELEASE: begin
                if (!w_g_req) begin
                    w_nxt_ack   = '0;
                    w_nxt_state = ST_IDLE;
                end
`ifdef CR_REQ_ARB_TIMEOUT_EN
                // Fires on the edge where the counter would reach all-ones.
                else if (&w_cnt_inc) begin
                    w_nxt_ack          = '0;
                    w_nxt_err          = 1'b1;
                    w_nxt_mask[r_last] = 1'b1;
                    w_nxt_cnt          = '0;
                    w_nxt_state        = ST_IDLE;
                end else begin
                    w_nxt_cnt   = w_cnt_inc;
                end
`endif
            end
            default: begin
                w_nxt_gnt   = '0;
                w_nxt_gvld  = 1'b0;
                w_nxt_gidx  = '0;
                w_nxt_ack   = '0;
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= IW'(pReqs - 1);
            r_ack   <= '0;
            r_gnt   <= '0;
            r_gvld  <= 1'b0;
            r_gidx  <= '0;
            r_abort <= 1'b0;
`ifdef CR_REQ_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_mask  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_nxt_state;
            r_last  <= w_nxt_last;
            r_ack   <= w_nxt_ack;
            r_gnt   <= w_nxt_gnt;
            r_gvld  <= w_nxt_gvld;
            r_gidx  <= w_nxt_gidx;
            r_abort <= w_nxt_abort;
`ifdef CR_REQ_ARB_TIMEOUT_EN
            r_cnt   <= w_nxt_cnt;
            r_mask  <= w_nxt_mask;
            r_err   <= w_nxt_err;
`endif
        end
    end

    assign Ack    = r_ack;
    assign Gnt    = r_gnt;
    assign GntVld = r_gvld;
    assign GntIdx = r_gidx;
    assign Abort  = r_abort;

endmodule
